// File: rtl/packet_buffers.sv
// Per-channel flit FIFOs with packet-length tracking, forwarding eligibility and credit return.
// Optional per-channel drop statistics are enabled by defining PACKET_BUFFERS_STATS_EN.
module packet_buffers #(
    parameter int NUM_BUFFERS      = 4,
    parameter int DEPTH            = 8,
    parameter int FLIT_WIDTH       = 32,
    parameter int PKT_LENGTH_WIDTH = 4,
    parameter int LEN_LSB          = 0,
    parameter int CUT_THROUGH      = 0
) (
    input  logic                                          CLK,
    input  logic                                          nRST,
    input  logic [NUM_BUFFERS-1:0]                        wen,
    input  logic [NUM_BUFFERS-1:0][FLIT_WIDTH-1:0]        wdata,
    input  logic [NUM_BUFFERS-1:0]                        ren,
    input  logic [NUM_BUFFERS-1:0]                        clear,
    output logic [NUM_BUFFERS-1:0][FLIT_WIDTH-1:0]        rdata,
    output logic [NUM_BUFFERS-1:0]                        full,
    output logic [NUM_BUFFERS-1:0]                        empty,
    output logic [NUM_BUFFERS-1:0][$clog2(DEPTH+1)-1:0]   count,
    output logic [NUM_BUFFERS-1:0]                        pkt_valid,
    output logic [NUM_BUFFERS-1:0]                        head,
    output logic [NUM_BUFFERS-1:0]                        overrun,
    output logic [NUM_BUFFERS-1:0]                        underrun,
    output logic [NUM_BUFFERS-1:0]                        credit
`ifdef PACKET_BUFFERS_STATS_EN
    ,
    output logic [NUM_BUFFERS-1:0][15:0]                  drop_cnt
`endif
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int PLW = PKT_LENGTH_WIDTH;

    for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_chan
        logic [FLIT_WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]         wr_ptr, rd_ptr;
        logic [CW-1:0]         cnt, pkt_cnt;
        logic [PLW-1:0]        wr_rem, rd_rem;
        logic [PLW-1:0]        wr_len, rd_len, wr_len_m1, rd_len_m1;
        logic                  is_full, is_empty;
        logic                  pop_ok, push_ok, drop, empty_pop;
        logic                  wr_done, rd_done;
        logic                  ovr_q, und_q, crd_q;

        assign is_full   = (cnt == CW'(DEPTH));
        assign is_empty  = (cnt == '0);

        // A pop frees a slot in the same cycle, so a write to a full channel still lands
        assign pop_ok    = ren[i] && !is_empty && !clear[i];
        assign push_ok   = wen[i] && !clear[i] && (!is_full || pop_ok);
        assign drop      = wen[i] && !clear[i] && is_full && !pop_ok;
        assign empty_pop = ren[i] && is_empty && !clear[i];

        // A length field of zero is a single-flit packet
        assign wr_len    = wdata[i][LEN_LSB +: PLW];
        assign rd_len    = mem[rd_ptr][LEN_LSB +: PLW];
        assign wr_len_m1 = (wr_len == '0) ? '0 : wr_len - 1'b1;
        assign rd_len_m1 = (rd_len == '0) ? '0 : rd_len - 1'b1;

        assign wr_done = push_ok && ((wr_rem == '0) ? (wr_len_m1 == '0) : (wr_rem == PLW'(1)));
        assign rd_done = pop_ok  && ((rd_rem == '0) ? (rd_len_m1 == '0) : (rd_rem == PLW'(1)));

        always_ff @(posedge CLK) begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata[i];
            end
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                cnt     <= '0;
                pkt_cnt <= '0;
                wr_rem  <= '0;
                rd_rem  <= '0;
                ovr_q   <= 1'b0;
                und_q   <= 1'b0;
                crd_q   <= 1'b0;
            end else if (clear[i]) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                cnt     <= '0;
                pkt_cnt <= '0;
                wr_rem  <= '0;
                rd_rem  <= '0;
                ovr_q   <= 1'b0;
                und_q   <= 1'b0;
                crd_q   <= 1'b0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                    wr_rem <= (wr_rem == '0) ? wr_len_m1 : wr_rem - 1'b1;
                end
                if (pop_ok) begin
                    rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                    rd_rem <= (rd_rem == '0) ? rd_len_m1 : rd_rem - 1'b1;
                end
                case ({push_ok, pop_ok})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
                if (wr_done && !rd_done) begin
                    pkt_cnt <= pkt_cnt + 1'b1;
                end else if (rd_done && !wr_done) begin
                    pkt_cnt <= pkt_cnt - 1'b1;
                end
                ovr_q <= drop;
                und_q <= empty_pop;
                crd_q <= pop_ok;
            end
        end

        assign rdata[i]    = mem[rd_ptr];
        assign full[i]     = is_full;
        assign empty[i]    = is_empty;
        assign count[i]    = cnt;
        assign head[i]     = (rd_rem == '0) && !is_empty;
        assign overrun[i]  = ovr_q;
        assign underrun[i] = und_q;
        assign credit[i]   = crd_q;

        if (CUT_THROUGH != 0) begin : g_cut
            assign pkt_valid[i] = !is_empty;
        end else begin : g_store
            // Store-and-forward eligibility lags the state change by one edge
            logic pv_q;
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    pv_q <= 1'b0;
                end else if (clear[i]) begin
                    pv_q <= 1'b0;
                end else begin
                    pv_q <= (pkt_cnt != '0) || is_full;
                end
            end
            assign pkt_valid[i] = pv_q;
        end

`ifdef PACKET_BUFFERS_STATS_EN
        logic [15:0] drops;
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                drops <= '0;
            end else if (clear[i]) begin
                drops <= '0;
            end else if (drop && (drops != 16'hFFFF)) begin
                drops <= drops + 1'b1;
            end
        end
        assign drop_cnt[i] = drops;
`endif
    end

endmodule

// File: tb/tb_packet_buffers.sv
// Directed scoreboard bench for packet_buffers: queued expected flits are popped and compared on reads.
module tb_packet_buffers;

    localparam int NB    = 4;
    localparam int DEPTH = 8;
    localparam int FW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                     CLK;
    logic                     nRST;
    logic [NB-1:0]            wen, ren, clear;
    logic [NB-1:0][FW-1:0]    wdata;
    logic [NB-1:0][FW-1:0]    rdata;
    logic [NB-1:0]            full, empty, pkt_valid, head, overrun, underrun, credit;
    logic [NB-1:0][CW-1:0]    count;
`ifdef PACKET_BUFFERS_STATS_EN
    logic [NB-1:0][15:0]      drop_cnt;
    int                       exp_drop [NB];
`endif

    int                       checks = 0;
    int                       fails  = 0;
    logic [FW-1:0]            sb [NB][$];
    logic [NB-1:0]            exp_credit, exp_over, exp_under, exp_full, exp_empty;
    int                       credit_total;

    packet_buffers dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .wen       (wen),
        .wdata     (wdata),
        .ren       (ren),
        .clear     (clear),
        .rdata     (rdata),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .pkt_valid (pkt_valid),
        .head      (head),
        .overrun   (overrun),
        .underrun  (underrun),
        .credit    (credit)
`ifdef PACKET_BUFFERS_STATS_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task tick;
        @(posedge CLK);
        #1;
    endtask

    task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task checkResetState(input string tag);
        checkOutput({tag, "_empty"},     32'(empty),     32'hF);
        checkOutput({tag, "_full"},      32'(full),      32'h0);
        checkOutput({tag, "_count"},     32'(count),     32'h0);
        checkOutput({tag, "_pkt_valid"}, 32'(pkt_valid), 32'h0);
        checkOutput({tag, "_head"},      32'(head),      32'h0);
        checkOutput({tag, "_overrun"},   32'(overrun),   32'h0);
        checkOutput({tag, "_underrun"},  32'(underrun),  32'h0);
        checkOutput({tag, "_credit"},    32'(credit),    32'h0);
`ifdef PACKET_BUFFERS_STATS_EN
        checkOutput({tag, "_drop_cnt"},  32'(drop_cnt),  32'h0);
`endif
    endtask

    // Reference behaviour: a clear wins, a pop frees space before the same-cycle write
    task applyStimulus;
        for (int ch = 0; ch < NB; ch++) begin
            exp_credit[ch] = 1'b0;
            exp_over[ch]   = 1'b0;
            exp_under[ch]  = 1'b0;
            if (clear[ch]) begin
                sb[ch].delete();
`ifdef PACKET_BUFFERS_STATS_EN
                exp_drop[ch] = 0;
`endif
            end else begin
                if (ren[ch]) begin
                    if (sb[ch].size() > 0) begin
                        checkOutput($sformatf("rdata_ch%0d", ch), rdata[ch], sb[ch][0]);
                        void'(sb[ch].pop_front());
                        exp_credit[ch] = 1'b1;
                    end else begin
                        exp_under[ch] = 1'b1;
                    end
                end
                if (wen[ch]) begin
                    if (sb[ch].size() < DEPTH) begin
                        sb[ch].push_back(wdata[ch]);
                    end else begin
                        exp_over[ch] = 1'b1;
`ifdef PACKET_BUFFERS_STATS_EN
                        if (exp_drop[ch] < 65535) exp_drop[ch]++;
`endif
                    end
                end
            end
        end
        tick();
        for (int ch = 0; ch < NB; ch++) begin
            exp_full[ch]  = (sb[ch].size() == DEPTH);
            exp_empty[ch] = (sb[ch].size() == 0);
            checkOutput($sformatf("count_ch%0d", ch), 32'(count[ch]), 32'(sb[ch].size()));
`ifdef PACKET_BUFFERS_STATS_EN
            checkOutput($sformatf("drop_cnt_ch%0d", ch), 32'(drop_cnt[ch]), 32'(exp_drop[ch]));
`endif
        end
        checkOutput("credit",   32'(credit),   32'(exp_credit));
        checkOutput("overrun",  32'(overrun),  32'(exp_over));
        checkOutput("underrun", 32'(underrun), 32'(exp_under));
        checkOutput("full",     32'(full),     32'(exp_full));
        checkOutput("empty",    32'(empty),    32'(exp_empty));
        credit_total += int'(credit[3]);
        wen   = '0;
        ren   = '0;
        clear = '0;
    endtask

    initial begin
        nRST = 1'b0; wen = '0; ren = '0; clear = '0; wdata = '0;
        credit_total = 0;
`ifdef PACKET_BUFFERS_STATS_EN
        for (int ch = 0; ch < NB; ch++) exp_drop[ch] = 0;
`endif
        #12;
        checkResetState("por");
        tick();
        nRST = 1'b1;

        $display("[TB] three-flit packet on ch0");
        wen[0] = 1'b1; wdata[0] = 32'hA000_0003; applyStimulus();
        checkOutput("pv0_flit1", 32'(pkt_valid[0]), 32'd0);
        checkOutput("head0_flit1", 32'(head[0]), 32'd1);
        wen[0] = 1'b1; wdata[0] = 32'hA001_0000; applyStimulus();
        checkOutput("pv0_flit2", 32'(pkt_valid[0]), 32'd0);
        wen[0] = 1'b1; wdata[0] = 32'hA002_0000; applyStimulus();
        checkOutput("head0_flit3", 32'(head[0]), 32'd1);
        checkOutput("count0_flit3", 32'(count[0]), 32'd3);
        applyStimulus();
        checkOutput("pv0_after", 32'(pkt_valid[0]), 32'd1);

        $display("[TB] fill ch1 and overrun");
        for (int k = 0; k < DEPTH; k++) begin
            wen[1] = 1'b1;
            wdata[1] = (k == 0) ? 32'h1000_0008 : (32'h1000_0000 | (32'(k) << 16));
            applyStimulus();
        end
        wen[1] = 1'b1; wdata[1] = 32'h10FF_0000; applyStimulus();
        checkOutput("overrun1_pulse", 32'(overrun[1]), 32'd1);
        applyStimulus();
        checkOutput("overrun1_once", 32'(overrun[1]), 32'd0);
        wen[1] = 1'b1; ren[1] = 1'b1; wdata[1] = 32'h1100_0001; applyStimulus();
        checkOutput("count1_stays8", 32'(count[1]), 32'd8);
        checkOutput("credit1_full_pop", 32'(credit[1]), 32'd1);

        $display("[TB] empty pop with write on ch2");
        wen[2] = 1'b1; ren[2] = 1'b1; wdata[2] = 32'h2000_0001; applyStimulus();
        checkOutput("underrun2", 32'(underrun[2]), 32'd1);
        checkOutput("head2", 32'(head[2]), 32'd1);
        applyStimulus();
        checkOutput("pv2_next", 32'(pkt_valid[2]), 32'd1);

        $display("[TB] two packets drained from ch3");
        wen[3] = 1'b1; wdata[3] = 32'h3000_0002; applyStimulus();
        wen[3] = 1'b1; wdata[3] = 32'h3001_0000; applyStimulus();
        wen[3] = 1'b1; wdata[3] = 32'h3002_0001; applyStimulus();
        applyStimulus();
        checkOutput("pv3_loaded", 32'(pkt_valid[3]), 32'd1);
        credit_total = 0;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] exp_heads, exp_pvs;
            exp_heads = 4'b0101;
            exp_pvs   = 4'b0111;
            checkOutput($sformatf("head3_pop%0d", k), 32'(head[3]), 32'(exp_heads[k]));
            ren[3] = 1'b1; applyStimulus();
            checkOutput($sformatf("pv3_pop%0d", k), 32'(pkt_valid[3]), 32'(exp_pvs[k]));
        end
        checkOutput("credit3_total", 32'(credit_total), 32'd3);
        checkOutput("underrun3_last", 32'(underrun[3]), 32'd1);

        $display("[TB] clear ch0 mid-packet");
        wen[0] = 1'b1; wdata[0] = 32'hB000_0004; applyStimulus();
        wen[0] = 1'b1; wdata[0] = 32'hB001_0000; applyStimulus();
        clear[0] = 1'b1; wen[0] = 1'b1; ren[0] = 1'b1; wdata[0] = 32'hB0FF_0002;
        wen[2] = 1'b1; wdata[2] = 32'h2100_0002;
        applyStimulus();
        checkOutput("pv0_cleared", 32'(pkt_valid[0]), 32'd0);
        checkOutput("pv2_kept", 32'(pkt_valid[2]), 32'd1);
        wen[0] = 1'b1; wdata[0] = 32'hC000_0001; applyStimulus();
        checkOutput("head0_after_clear", 32'(head[0]), 32'd1);
        applyStimulus();
        checkOutput("pv0_after_clear", 32'(pkt_valid[0]), 32'd1);

        $display("[TB] drain ch1 across pointer wrap");
        for (int k = 0; k < DEPTH; k++) begin
            ren[1] = 1'b1; applyStimulus();
        end
        wen[1] = 1'b1; wdata[1] = 32'h1300_0003; applyStimulus();
        wen[3] = 1'b1; wdata[3] = 32'h3000_0005; applyStimulus();
        ren[2] = 1'b1; wen[3] = 1'b1; wdata[3] = 32'h3001_0000; applyStimulus();

        $display("[TB] asynchronous reset with partial packets");
        #2;
        nRST = 1'b0;
        #1;
        checkResetState("async");
        for (int ch = 0; ch < NB; ch++) begin
            sb[ch].delete();
`ifdef PACKET_BUFFERS_STATS_EN
            exp_drop[ch] = 0;
`endif
        end
        tick();
        nRST = 1'b1;
        wen[1] = 1'b1; wdata[1] = 32'h1400_0001; applyStimulus();
        checkOutput("head1_post_reset", 32'(head[1]), 32'd1);
        applyStimulus();
        checkOutput("pv1_post_reset", 32'(pkt_valid[1]), 32'd1);
        ren[1] = 1'b1; applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
